// File: rtl/encoder_pkg.sv
// Shared widths and the fixed-priority encode used by the request encoder.
package encoder_pkg;

  localparam int REQ_W  = 4;
  localparam int CODE_W = 2;

  // Highest set bit wins: bit 3 has top priority, bit 0 the lowest.
  // An all-zero input returns code 0; callers gate on "any bit set".
  function automatic logic [CODE_W-1:0] prioEncode(input logic [REQ_W-1:0] req);
    logic [CODE_W-1:0] code;
    code = '0;
    for (int i = 0; i < REQ_W; i++) begin
      if (req[i]) begin
        code = CODE_W'(i);
      end
    end
    return code;
  endfunction

  // True when two or more bits are set at once.
  function automatic logic multiHot(input logic [REQ_W-1:0] req);
    return (req & (req - REQ_W'(1))) != '0;
  endfunction

endpackage

// File: rtl/code_fifo.sv
// First-word-fall-through queue: the head entry is presented combinationally
// whenever the queue is non-empty, and reads zero when it is empty.
module code_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             doPush, doPop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = empty_o ? '0 : mem_q[rptr_q];

  // A push into a full queue is only taken when a pop frees a slot in the
  // same cycle; a pop from an empty queue is never taken.
  assign doPop  = pop_i & ~empty_o;
  assign doPush = push_i & (~full_o | doPop);

  // Next pointer and occupancy values; pointers wrap naturally because the
  // depth is a power of two.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (doPush) begin
      wptr_d = PTR_W'(wptr_q + 1'b1);
    end
    if (doPop) begin
      rptr_d = PTR_W'(rptr_q + 1'b1);
    end
    if (doPush && !doPop) begin
      count_d = CNT_W'(count_q + 1'b1);
    end else if (doPop && !doPush) begin
      count_d = CNT_W'(count_q - 1'b1);
    end
  end

  // Pointer and count registers; reset empties the queue immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage array; contents need no reset since the count masks stale data.
  always_ff @(posedge clk) begin
    if (doPush) begin
      mem_q[wptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/encoder_seq.sv
// Turns rising edges on asynchronous request lines into a queue of binary
// codes. Requests are synchronized, edge-detected, priority-encoded and
// pushed into a small FWFT queue drained by a valid/ready consumer.
module encoder_seq
  import encoder_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [REQ_W-1:0]              req_in,
  output logic [CODE_W-1:0]             code_out,
  output logic                          code_valid,
  input  logic                          code_ready,
  output logic                          multi_err,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  logic [REQ_W-1:0]  sync_q [SYNC_STAGES];
  logic [REQ_W-1:0]  prev_q;
  logic [REQ_W-1:0]  syncVal;
  logic [REQ_W-1:0]  riseVec;
  logic [CODE_W-1:0] pushCode;
  logic              pushReq;
  logic              popReq;
  logic              fifoFull;
  logic              fifoEmpty;

  // Synchronizer chain per request bit; reset clears every stage so edges
  // in flight are discarded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= '0;
      end
    end else begin
      sync_q[0] <= req_in;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
    end
  end

  assign syncVal = sync_q[SYNC_STAGES-1];

  // Last synchronized value; clearing it on reset makes a request held
  // across reset look like one fresh edge after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= '0;
    end else begin
      prev_q <= syncVal;
    end
  end

  // Edge detect and encode: only the highest-priority edge is queued, and
  // simultaneous edges are flagged in the same cycle as the push.
  always_comb begin
    riseVec   = syncVal & ~prev_q;
    pushReq   = |riseVec;
    pushCode  = prioEncode(riseVec);
    multi_err = multiHot(riseVec);
  end

  // Consumer handshake: valid depends only on queue state.
  assign code_valid = ~fifoEmpty;
  assign popReq     = code_valid & code_ready;
  assign overflow   = pushReq & fifoFull & ~popReq;

  code_fifo #(
    .WIDTH (CODE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (pushReq),
    .data_i  (pushCode),
    .pop_i   (popReq),
    .data_o  (code_out),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty),
    .count_o (fifo_count)
  );

endmodule

// File: tb/tb_encoder_seq.sv
// Directed bench for encoder_seq: latency, priority/multi-edge, overflow,
// full-queue push+pop, and asynchronous reset with a held request.
module tb_encoder_seq;

  logic       clk;
  logic       rst_n;
  logic [3:0] req_in;
  logic [1:0] code_out;
  logic       code_valid;
  logic       code_ready;
  logic       multi_err;
  logic       overflow;
  logic [2:0] fifo_count;

  int checkCount;
  int errorCount;

  encoder_seq #(
    .FIFO_DEPTH  (4),
    .SYNC_STAGES (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_in     (req_in),
    .code_out   (code_out),
    .code_valid (code_valid),
    .code_ready (code_ready),
    .multi_err  (multi_err),
    .overflow   (overflow),
    .fifo_count (fifo_count)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input int observed, input int expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d at t=%0t", tag, observed, expected, $time);
    end
  endtask

  // Drive the request lines and the consumer ready.
  task automatic applyStimulus(input logic [3:0] req, input logic rdy);
    req_in     = req;
    code_ready = rdy;
  endtask

  // Advance n rising edges, landing 1 unit after the last one.
  task automatic waitCycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One-cycle-wide pulse on a single request bit; returns just after the
  // edge where the synchronized rise becomes visible.
  task automatic pulseBit(input int idx, input logic rdy);
    logic [3:0] v;
    v = 4'b0001 << idx;
    applyStimulus(v, rdy);
    waitCycles(1);
    applyStimulus(4'b0000, rdy);
    waitCycles(1);
  endtask

  initial begin
    checkCount = 0;
    errorCount = 0;
    rst_n      = 1'b0;
    applyStimulus(4'b0000, 1'b1);

    // Reset state
    #2;
    checkOutput("rst_valid", int'(code_valid), 0);
    checkOutput("rst_code", int'(code_out), 0);
    checkOutput("rst_count", int'(fifo_count), 0);
    checkOutput("rst_multi", int'(multi_err), 0);
    checkOutput("rst_ovf", int'(overflow), 0);
    waitCycles(2);
    rst_n = 1'b1;
    waitCycles(2);

    // Single pulse on bit 2 with ready high: code 2 for exactly one cycle
    $display("[TB] single pulse latency");
    applyStimulus(4'b0100, 1'b1);
    waitCycles(1);
    applyStimulus(4'b0000, 1'b1);
    waitCycles(1);
    checkOutput("lat_k1_valid", int'(code_valid), 0);
    checkOutput("lat_k1_multi", int'(multi_err), 0);
    waitCycles(1);
    checkOutput("lat_k2_valid", int'(code_valid), 1);
    checkOutput("lat_k2_code", int'(code_out), 2);
    checkOutput("lat_k2_count", int'(fifo_count), 1);
    waitCycles(1);
    checkOutput("lat_k3_valid", int'(code_valid), 0);
    checkOutput("lat_k3_count", int'(fifo_count), 0);
    checkOutput("lat_k3_code", int'(code_out), 0);

    // Simultaneous edges 0000 -> 1011: one code 3 plus multi_err
    $display("[TB] multi-edge priority");
    applyStimulus(4'b1011, 1'b0);
    waitCycles(2);
    checkOutput("multi_pulse", int'(multi_err), 1);
    checkOutput("multi_pre_count", int'(fifo_count), 0);
    waitCycles(1);
    checkOutput("multi_after", int'(multi_err), 0);
    checkOutput("multi_count", int'(fifo_count), 1);
    checkOutput("multi_code", int'(code_out), 3);
    waitCycles(3);
    checkOutput("held_count", int'(fifo_count), 1);
    applyStimulus(4'b0000, 1'b1);
    waitCycles(1);
    checkOutput("multi_drain", int'(fifo_count), 0);
    waitCycles(4);
    checkOutput("fall_nothing", int'(fifo_count), 0);
    checkOutput("fall_valid", int'(code_valid), 0);

    // Fill queue with codes 0,1,2,3 then overflow on a fifth pulse
    $display("[TB] fill and overflow");
    pulseBit(0, 1'b0);
    pulseBit(1, 1'b0);
    pulseBit(2, 1'b0);
    pulseBit(3, 1'b0);
    waitCycles(2);
    checkOutput("fill_count", int'(fifo_count), 4);
    checkOutput("fill_ovf_idle", int'(overflow), 0);
    pulseBit(0, 1'b0);
    checkOutput("ovf_pulse", int'(overflow), 1);
    waitCycles(1);
    checkOutput("ovf_after", int'(overflow), 0);
    checkOutput("ovf_count", int'(fifo_count), 4);
    applyStimulus(4'b0000, 1'b1);
    for (int i = 0; i < 4; i++) begin
      checkOutput("drain_code", int'(code_out), i);
      waitCycles(1);
    end
    checkOutput("drain_empty", int'(fifo_count), 0);

    // Full queue with push and pop in the same cycle
    $display("[TB] full push+pop");
    pulseBit(1, 1'b0);
    pulseBit(2, 1'b0);
    pulseBit(3, 1'b0);
    pulseBit(0, 1'b0);
    waitCycles(2);
    checkOutput("full2_count", int'(fifo_count), 4);
    pulseBit(2, 1'b0);
    applyStimulus(4'b0000, 1'b1);
    #1;
    checkOutput("pp_no_ovf", int'(overflow), 0);
    waitCycles(1);
    checkOutput("pp_count", int'(fifo_count), 4);
    begin
      int expOrder [4];
      expOrder = '{2, 3, 0, 2};
      for (int i = 0; i < 4; i++) begin
        checkOutput("pp_order", int'(code_out), expOrder[i]);
        waitCycles(1);
      end
    end
    checkOutput("pp_empty", int'(fifo_count), 0);

    // Asynchronous reset with 3 queued codes and a request held through it
    $display("[TB] async reset mid-operation");
    pulseBit(0, 1'b0);
    pulseBit(1, 1'b0);
    pulseBit(2, 1'b0);
    waitCycles(2);
    checkOutput("pre_rst_count", int'(fifo_count), 3);
    applyStimulus(4'b0001, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_count", int'(fifo_count), 0);
    checkOutput("arst_valid", int'(code_valid), 0);
    checkOutput("arst_code", int'(code_out), 0);
    waitCycles(2);
    rst_n = 1'b1;
    waitCycles(6);
    checkOutput("rel_count", int'(fifo_count), 1);
    checkOutput("rel_code", int'(code_out), 0);
    checkOutput("rel_valid", int'(code_valid), 1);
    applyStimulus(4'b0001, 1'b1);
    waitCycles(1);
    checkOutput("rel_drain", int'(fifo_count), 0);
    waitCycles(4);
    checkOutput("rel_once", int'(fifo_count), 0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
